// File: rtl/onboard_debug_ctrl.sv
// rtl/onboard_debug_ctrl.sv - board debug read controller: keys/switches to debug reads, HEX latch
//
// Purpose: turns debounced push-button presses and switch settings into read
// requests on the cores' debug port and latches each response for HEX5..HEX0.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   sw_i           read address from switches (asynchronous, synchronized here)
//   key_n_i[2:0]   KEY0=read @SW, KEY1=next core, KEY2=read @last+1 (active-low, async)
//   req_valid_o    read request valid; req_core_o/req_addr_o held until req_ready_i
//   req_ready_i    fabric accepts request
//   rsp_valid_i    one-cycle read data valid, rsp_data_i read data
//   hex_data_o     value shown on HEX5..HEX0 (nibble 0 -> HEX0)
//   core_sel_o     currently selected core
//   busy_o         controller is not idle
//   err_o          sticky: last read timed out
module onboard_debug_ctrl #(
  parameter int NUM_CORES    = 4,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 24,
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            sw_i,
  input  logic [2:0]                   key_n_i,
  output logic                         req_valid_o,
  input  logic                         req_ready_i,
  output logic [$clog2(NUM_CORES)-1:0] req_core_o,
  output logic [ADDR_W-1:0]            req_addr_o,
  input  logic                         rsp_valid_i,
  input  logic [DATA_W-1:0]            rsp_data_i,
  output logic [DATA_W-1:0]            hex_data_o,
  output logic [$clog2(NUM_CORES)-1:0] core_sel_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DATA_W-1:0] HEX_ERR = {(DATA_W / 4){4'hE}};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              state, state_n;
  logic [2:0]          key_s1, key_s2;
  logic [ADDR_W-1:0]   sw_s1, sw_s2;
  logic [DB_W-1:0]     db_cnt [3];
  logic [2:0]          press;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [CORE_W-1:0]   core_sel_q, core_sel_n;
  logic [CORE_W-1:0]   req_core_q, req_core_n;
  logic [DATA_W-1:0]   hex_q, hex_n;
  logic                err_q, err_n;
  logic [TO_W-1:0]     tcnt_q, tcnt_n;

  // Two-flop synchronizers; keys reset to the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= 3'b111;
      key_s2 <= 3'b111;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n_i;
      key_s2 <= key_s1;
      sw_s1  <= sw_i;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: the counter saturates at DEBOUNCE_CYC so the pulse fires once
  // per press and only re-arms after the key has been seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      press <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (key_s2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != DB_W'(DEBOUNCE_CYC)) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
          press[i]  <= (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      core_sel_q <= '0;
      req_core_q <= '0;
      hex_q      <= '0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      core_sel_q <= core_sel_n;
      req_core_q <= req_core_n;
      hex_q      <= hex_n;
      err_q      <= err_n;
      tcnt_q     <= tcnt_n;
    end
  end

  // addr_q doubles as last_addr: it only changes when a new request is issued.
  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    core_sel_n  = core_sel_q;
    req_core_n  = req_core_q;
    hex_n       = hex_q;
    err_n       = err_q;
    tcnt_n      = tcnt_q;
    req_valid_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (press[0]) begin
          addr_n     = sw_s2;
          req_core_n = core_sel_q;
          err_n      = 1'b0;
          state_n    = S_REQ;
        end else if (press[2]) begin
          addr_n     = addr_q + 1'b1;
          req_core_n = core_sel_q;
          err_n      = 1'b0;
          state_n    = S_REQ;
        end else if (press[1]) begin
          core_sel_n = (core_sel_q == CORE_W'(NUM_CORES - 1)) ? '0 : core_sel_q + 1'b1;
        end
      end
      S_REQ: begin
        req_valid_o = 1'b1;
        if (req_ready_i) begin
          tcnt_n  = '0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving in the timeout cycle takes precedence.
        if (rsp_valid_i) begin
          hex_n   = rsp_data_i;
          state_n = S_IDLE;
        end else if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          hex_n   = HEX_ERR;
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign req_core_o = req_core_q;
  assign req_addr_o = addr_q;
  assign hex_data_o = hex_q;
  assign core_sel_o = core_sel_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_onboard_debug_ctrl.sv
// tb/tb_onboard_debug_ctrl.sv - scoreboard bench for onboard_debug_ctrl
module tb_onboard_debug_ctrl;

  localparam int NCORES = 4;
  localparam int AW     = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  sw = '0;
  logic [2:0]  key_n = 3'b111;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_core;
  logic [9:0]  req_addr;
  logic        rsp_valid;
  logic [23:0] rsp_data;
  logic [23:0] hex_data;
  logic [1:0]  core_sel;
  logic        busy;
  logic        err;

  onboard_debug_ctrl dut (
    .clk(clk), .rst(rst), .sw_i(sw), .key_n_i(key_n),
    .req_valid_o(req_valid), .req_ready_i(req_ready),
    .req_core_o(req_core), .req_addr_o(req_addr),
    .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data),
    .hex_data_o(hex_data), .core_sel_o(core_sel),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct { int core; int addr; } req_t;
  typedef struct { logic [23:0] hex; logic err; bit tmo; } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          exp_core = 0;
  int          last_addr = 0;
  logic [23:0] exp_hex = '0;

  // fabric configuration
  bit          fabric_en = 1'b1;
  int          cfg_rdly = 0;
  int          cfg_sdly = 0;
  bit          cfg_drop = 1'b0;
  logic [23:0] cfg_data = '0;

  int op;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Fabric responder
  initial begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (fabric_en && req_valid && !rst) begin
        repeat (cfg_rdly) @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        if (!cfg_drop) begin
          repeat (cfg_sdly) @(negedge clk);
          rsp_valid = 1'b1;
          rsp_data  = cfg_data;
          @(negedge clk);
          rsp_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a handshake or finishes a read
  int unsigned cyc = 0;
  int unsigned hs_cyc = 0;
  logic        mon_prev_busy = 1'b0;
  logic        mon_hold = 1'b0;
  logic [9:0]  mon_addr = '0;
  logic [1:0]  mon_core = '0;
  req_t        mon_r;
  rsp_t        mon_e;

  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      mon_prev_busy = 1'b0;
      mon_hold      = 1'b0;
    end else begin
      if (req_valid) begin
        check("req_err_cleared", 32'(err), 32'd0);
        if (mon_hold) begin
          check("req_addr_stable", 32'(req_addr), 32'(mon_addr));
          check("req_core_stable", 32'(req_core), 32'(mon_core));
        end
        if (req_ready) begin
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: core %0d addr %0h, none expected", req_core, req_addr);
          end else begin
            mon_r = req_q.pop_front();
            check("req_core", 32'(req_core), 32'(mon_r.core));
            check("req_addr", 32'(req_addr), 32'(mon_r.addr));
          end
          hs_cyc   = cyc;
          mon_hold = 1'b0;
        end else begin
          mon_hold = 1'b1;
          mon_addr = req_addr;
          mon_core = req_core;
        end
      end else begin
        mon_hold = 1'b0;
      end
      if (mon_prev_busy && !busy) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: hex %0h, no read expected", hex_data);
        end else begin
          mon_e = rsp_q.pop_front();
          check("hex_data", 32'(hex_data), 32'(mon_e.hex));
          check("err", 32'(err), 32'(mon_e.err));
          if (mon_e.tmo)
            check("timeout_len_in_range", 32'((cyc - hs_cyc) >= 255 && (cyc - hs_cyc) <= 257), 32'd1);
        end
      end
      mon_prev_busy = busy;
    end
  end

  task automatic press(input logic [2:0] mask, input int n);
    @(negedge clk);
    key_n = ~mask;
    repeat (n) @(negedge clk);
    key_n = 3'b111;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 600) begin
      @(negedge clk);
      i++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // k selects the read kind (0: @SW, 2: @last+1); mask is the full set of keys pressed
  task automatic start_read(input int k, input logic [9:0] s, input int rd, input int sd,
                            input bit drop, input logic [23:0] d, input logic [2:0] mask);
    req_t r;
    rsp_t e;
    int   a;
    a = (k == 0) ? int'(s) : (last_addr + 1) % (1 << AW);
    r.core = exp_core;
    r.addr = a;
    req_q.push_back(r);
    e.hex = drop ? 24'hEEEEEE : d;
    e.err = drop;
    e.tmo = drop;
    rsp_q.push_back(e);
    exp_hex   = e.hex;
    last_addr = a;
    sw        = s;
    cfg_rdly  = rd;
    cfg_sdly  = sd;
    cfg_drop  = drop;
    cfg_data  = d;
    press(mask, 20 + int'($urandom_range(0, 6)));
  endtask

  task automatic next_core(input string name);
    press(3'b010, 20 + int'($urandom_range(0, 6)));
    exp_core = (exp_core + 1) % NCORES;
    check(name, 32'(core_sel), 32'(exp_core));
  endtask

  task automatic idle_rsp();
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data  = 24'($urandom);
    @(negedge clk);
    rsp_valid = 1'b0;
    @(negedge clk);
    check("idle_rsp_ignored", 32'(hex_data), 32'(exp_hex));
    check("idle_rsp_not_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    logic seen;
    repeat (3) @(negedge clk);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_core", 32'(req_core), 32'd0);
    check("rst_req_addr", 32'(req_addr), 32'd0);
    check("rst_hex", 32'(hex_data), 32'd0);
    check("rst_core_sel", 32'(core_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // basic read: KEY0 at SW=155, response 3 cycles after handshake
    start_read(0, 10'h155, 0, 3, 1'b0, 24'hABC123, 3'b001);
    wait_idle();

    // glitch shorter than the debounce window
    press(3'b001, 10);
    seen = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      seen = seen | busy;
    end
    check("glitch_no_busy", 32'(seen), 32'd0);

    // core select cycles 1,2,3,0,1, then read on core 1
    for (int j = 0; j < 5; j++) next_core("core_sel_step");
    check("core_sel_final", 32'(core_sel), 32'd1);
    start_read(0, 10'h0A5, 1, 2, 1'b0, 24'h5A5A5A, 3'b001);
    wait_idle();

    // address wrap with a slow ready
    start_read(0, 10'h3FF, 0, 0, 1'b0, 24'h000FFF, 3'b001);
    wait_idle();
    start_read(2, 10'h123, 7, 1, 1'b0, 24'h777000, 3'b100);
    wait_idle();

    // timeout, then a successful read clears err
    start_read(2, 10'h000, 0, 0, 1'b1, 24'h0, 3'b100);
    wait_idle();
    check("err_sticky", 32'(err), 32'd1);
    start_read(0, 10'h042, 2, 5, 1'b0, 24'h600D00, 3'b001);
    wait_idle();

    // response in the timeout cycle wins
    start_read(0, 10'h111, 0, 254, 1'b0, 24'hC0FFEE, 3'b001);
    wait_idle();

    // coincident presses: KEY0 > KEY2 > KEY1
    start_read(0, 10'h2C3, 0, 1, 1'b0, 24'h0A0B0C, 3'b011);
    wait_idle();
    check("prio_core_keep1", 32'(core_sel), 32'(exp_core));
    start_read(2, 10'h001, 0, 1, 1'b0, 24'h1E2E3E, 3'b110);
    wait_idle();
    check("prio_core_keep2", 32'(core_sel), 32'(exp_core));
    start_read(0, 10'h300, 0, 1, 1'b0, 24'h4D4D4D, 3'b101);
    wait_idle();

    // KEY1 while waiting for a slow response is ignored
    start_read(0, 10'h0F0, 0, 80, 1'b0, 24'h987654, 3'b001);
    press(3'b010, 22);
    wait_idle();
    check("key1_in_wait_ignored", 32'(core_sel), 32'(exp_core));

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      op = int'($urandom_range(0, 2));
      if (op == 1) begin
        next_core("core_sel_rand");
      end else begin
        start_read(op, 10'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 12)),
                   ($urandom_range(0, 9) == 0), 24'($urandom), 3'b001 << op);
        wait_idle();
      end
      if ($urandom_range(0, 3) == 0) idle_rsp();
    end

    // reset in the middle of a request; late response ignored
    fabric_en = 1'b0;
    sw = 10'h2AA;
    @(negedge clk);
    key_n = 3'b110;
    i = 0;
    while (!req_valid && i < 60) begin
      @(negedge clk);
      i++;
    end
    check("rst_test_req_seen", 32'(req_valid), 32'd1);
    repeat (2) @(negedge clk);
    key_n = 3'b111;
    rst = 1'b1;
    #1;
    check("midrst_req_valid", 32'(req_valid), 32'd0);
    check("midrst_hex", 32'(hex_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_core_sel", 32'(core_sel), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_core = 0;
    last_addr = 0;
    exp_hex = '0;
    repeat (2) @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data  = 24'h123456;
    @(negedge clk);
    rsp_valid = 1'b0;
    @(negedge clk);
    check("late_rsp_hex", 32'(hex_data), 32'd0);
    check("late_rsp_busy", 32'(busy), 32'd0);
    fabric_en = 1'b1;

    // last_addr restarts from 0 after reset
    start_read(2, 10'h3C3, 0, 2, 1'b0, 24'hBEEF01, 3'b100);
    wait_idle();

    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
